cache_victim_fill_ctrl: RTL and testbench

- Sequences cache line replacement on a miss.
- Consumes the one-hot pseudo-random VictimWay produced by the cache LFSR replacement block.
- Picks the final way to replace (first invalid way has priority over the LFSR pick), writes back a dirty victim, fetches the new line beat by beat, then pulses LFSRWriteEn so the LFSR advances once per LFSR-chosen replacement.
- Sits between cache tag/valid arrays, the LFSR, and the bus interface.

---
 rtl/cache_victim_fill_ctrl.sv | 178 +++++++++++++++++
 tb/tb_cache_victim_fill_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_victim_fill_ctrl.sv
// Cache line replacement sequencer: victim select, writeback, line fill.
// Define CACHE_FILL_STATS_EN to add EvictCount / WritebackCount outputs.
module cache_victim_fill_ctrl #(
    parameter int NUMWAYS      = 4,
    parameter int BEATSPERLINE = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            FlushStage,
    input  logic                            Miss,
    input  logic [NUMWAYS-1:0]              ValidWay,
    input  logic [NUMWAYS-1:0]              DirtyWay,
    input  logic [NUMWAYS-1:0]              VictimWay,
    input  logic                            BusReady,
    output logic [NUMWAYS-1:0]              SelWay,
    output logic                            WriteBackReq,
    output logic                            FetchReq,
    output logic [$clog2(BEATSPERLINE)-1:0] BeatCount,
    output logic                            ClearDirty,
    output logic                            SetValid,
    output logic                            FillDone,
    output logic                            LFSRWriteEn,
    output logic                            Busy
`ifdef CACHE_FILL_STATS_EN
    ,
    output logic [31:0]                     EvictCount,
    output logic [31:0]                     WritebackCount
`endif
);

    localparam int BW = $clog2(BEATSPERLINE);
    localparam logic [BW-1:0] LASTBEAT = BW'(BEATSPERLINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        DONE
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [NUMWAYS-1:0] selway_n;
    logic               usedlfsr;
    logic               usedlfsr_n;
    logic [BW-1:0]      beat_n;

    logic [NUMWAYS-1:0] inv_pick;
    logic [NUMWAYS-1:0] lfsr_pick;
    logic [NUMWAYS-1:0] pick;
    logic               any_inv;
    logic               need_wb;
    logic               last_beat;

    // Lowest-index invalid way (descending scan so the lowest hit wins).
    always_comb begin
        inv_pick = '0;
        for (int i = NUMWAYS - 1; i >= 0; i--) begin
            if (!ValidWay[i]) begin
                inv_pick    = '0;
                inv_pick[i] = 1'b1;
            end
        end
    end

    // Lowest set bit of the LFSR pick; an all-zero pick falls back to way 0.
    always_comb begin
        lfsr_pick    = '0;
        lfsr_pick[0] = 1'b1;
        for (int i = NUMWAYS - 1; i >= 0; i--) begin
            if (VictimWay[i]) begin
                lfsr_pick    = '0;
                lfsr_pick[i] = 1'b1;
            end
        end
    end

    // Final way choice and whether its current contents must be written back.
    always_comb begin
        any_inv   = ~&ValidWay;
        pick      = any_inv ? inv_pick : lfsr_pick;
        need_wb   = |(pick & ValidWay & DirtyWay);
        last_beat = (BeatCount == LASTBEAT);
    end

    // State, latched way choice and beat index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            SelWay    <= '0;
            usedlfsr  <= 1'b0;
            BeatCount <= '0;
        end else begin
            state     <= state_n;
            SelWay    <= selway_n;
            usedlfsr  <= usedlfsr_n;
            BeatCount <= beat_n;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_n      = state;
        selway_n     = SelWay;
        usedlfsr_n   = usedlfsr;
        beat_n       = BeatCount;
        WriteBackReq = 1'b0;
        FetchReq     = 1'b0;
        ClearDirty   = 1'b0;
        SetValid     = 1'b0;
        FillDone     = 1'b0;
        LFSRWriteEn  = 1'b0;
        unique case (state)
            IDLE: begin
                if (Miss && !FlushStage) begin
                    selway_n   = pick;
                    usedlfsr_n = !any_inv;
                    beat_n     = '0;
                    state_n    = need_wb ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                WriteBackReq = 1'b1;
                if (BusReady) begin
                    beat_n = BeatCount + 1'b1;
                    if (last_beat) begin
                        ClearDirty = 1'b1;
                        beat_n     = '0;
                        state_n    = FETCH;
                    end
                end
            end
            FETCH: begin
                FetchReq = 1'b1;
                if (BusReady) begin
                    beat_n = BeatCount + 1'b1;
                    if (last_beat) begin
                        beat_n  = '0;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                SetValid    = 1'b1;
                FillDone    = 1'b1;
                // A flushed instruction must not consume an LFSR step.
                LFSRWriteEn = usedlfsr && !FlushStage;
                state_n     = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Busy is a pure state decode.
    always_comb begin
        Busy = (state != IDLE);
    end

`ifdef CACHE_FILL_STATS_EN
    // Saturating counters of LFSR evictions and completed writebacks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            EvictCount     <= '0;
            WritebackCount <= '0;
        end else begin
            if (state == DONE && usedlfsr && EvictCount != '1) begin
                EvictCount <= EvictCount + 32'd1;
            end
            if (ClearDirty && WritebackCount != '1) begin
                WritebackCount <= WritebackCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_victim_fill_ctrl.sv
// Randomized scoreboard bench for cache_victim_fill_ctrl.
// Driver pushes expected replacements; a negedge monitor checks them.
module tb_cache_victim_fill_ctrl;

    localparam int N  = 4;
    localparam int B  = 4;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          FlushStage = 1'b0;
    logic          Miss = 1'b0;
    logic [N-1:0]  ValidWay = '1;
    logic [N-1:0]  DirtyWay = '0;
    logic [N-1:0]  VictimWay = 4'b0001;
    logic          BusReady = 1'b0;
    logic [N-1:0]  SelWay;
    logic          WriteBackReq;
    logic          FetchReq;
    logic [BW-1:0] BeatCount;
    logic          ClearDirty;
    logic          SetValid;
    logic          FillDone;
    logic          LFSRWriteEn;
    logic          Busy;

    cache_victim_fill_ctrl #(
        .NUMWAYS      (N),
        .BEATSPERLINE (B)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .FlushStage   (FlushStage),
        .Miss         (Miss),
        .ValidWay     (ValidWay),
        .DirtyWay     (DirtyWay),
        .VictimWay    (VictimWay),
        .BusReady     (BusReady),
        .SelWay       (SelWay),
        .WriteBackReq (WriteBackReq),
        .FetchReq     (FetchReq),
        .BeatCount    (BeatCount),
        .ClearDirty   (ClearDirty),
        .SetValid     (SetValid),
        .FillDone     (FillDone),
        .LFSRWriteEn  (LFSRWriteEn),
        .Busy         (Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] sel;
        bit           wb;
        bit           used;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    bit   mon_en = 0;
    int   br_mode = 0;
    int   wbn = 0;
    int   fn = 0;
    bit   pd = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, req, $time);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Replacement rule: first invalid way, else lowest LFSR bit, else way 0.
    function automatic exp_t model(input logic [N-1:0] v,
                                   input logic [N-1:0] d,
                                   input logic [N-1:0] vic);
        exp_t e;
        int   idx;
        idx = -1;
        for (int i = 0; i < N; i++)
            if (!v[i] && idx < 0) idx = i;
        e.used = (idx < 0);
        if (idx < 0)
            for (int i = 0; i < N; i++)
                if (vic[i] && idx < 0) idx = i;
        if (idx < 0) idx = 0;
        e.sel      = '0;
        e.sel[idx] = 1'b1;
        e.wb       = v[idx] && d[idx];
        return e;
    endfunction

    // Bus handshake generator: random, alternating, or driven by hand.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (br_mode)
                0: BusReady = ($urandom % 3 != 0);
                1: BusReady = ~BusReady;
                default: ;
            endcase
        end
    end

    // Monitor: per-cycle beat/pulse checks and scoreboard pop at FillDone.
    always @(negedge clk) begin
        exp_t e;
        bit   br;
        if (!mon_en || reset) begin
            pd = 0;
        end else begin
            br = BusReady;
            if (pd) chk("idle_after_done", {31'd0, Busy}, 0);
            chk("pulse_pair", {31'd0, SetValid}, {31'd0, FillDone});
            chk("req_excl", {31'd0, WriteBackReq & FetchReq}, 0);
            if (WriteBackReq || FetchReq) begin
                if (q.size() == 0) chk("req_no_txn", 1, 0);
                else chk("selway_busy", {28'd0, SelWay}, {28'd0, q[0].sel});
            end
            if (WriteBackReq) begin
                chk("wb_beat", {30'd0, BeatCount}, wbn);
                chk("clear_dirty", {31'd0, ClearDirty},
                    {31'd0, br && wbn == B - 1});
                if (br) wbn++;
            end else begin
                chk("clear_dirty_off", {31'd0, ClearDirty}, 0);
            end
            if (FetchReq) begin
                chk("fetch_beat", {30'd0, BeatCount}, fn);
                if (br) fn++;
            end
            if (FillDone) begin
                if (q.size() == 0) begin
                    chk("done_no_txn", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sel_way", {28'd0, SelWay}, {28'd0, e.sel});
                    chk("wb_beats", wbn, e.wb ? B : 0);
                    chk("fetch_beats", fn, B);
                    chk("lfsr_we", {31'd0, LFSRWriteEn},
                        {31'd0, e.used && !FlushStage});
                end
                wbn = 0;
                fn  = 0;
                done_cnt++;
            end else begin
                chk("lfsr_we_off", {31'd0, LFSRWriteEn}, 0);
            end
            pd = FillDone;
        end
    end

    // One replacement; entered and left at posedge+1 of an IDLE cycle.
    task automatic run_txn(input logic [N-1:0] v, input logic [N-1:0] d,
                           input logic [N-1:0] vic, input int pre,
                           input int fd, input int brm);
        int start;
        int cyc;
        br_mode = brm;
        repeat (pre) begin
            Miss       = 1'b1;
            FlushStage = 1'b1;
            @(negedge clk);
            chk("flush_blocks", {31'd0, Busy}, 0);
            @(posedge clk);
            #1;
        end
        Miss       = 1'b1;
        FlushStage = 1'b0;
        ValidWay   = v;
        DirtyWay   = d;
        VictimWay  = vic;
        q.push_back(model(v, d, vic));
        start = done_cnt;
        cyc   = 0;
        @(posedge clk);
        while (done_cnt == start) begin
            if (cyc > 400) begin
                chk("done_timeout", 0, 1);
                finish_run();
            end
            cyc++;
            #1;
            ValidWay   = N'($urandom);
            DirtyWay   = N'($urandom);
            VictimWay  = N'($urandom);
            Miss       = ($urandom % 4 != 0);
            FlushStage = (fd == 2) ? 1'($urandom) : 1'(fd);
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        #200000;
        chk("global_timeout", 0, 1);
        finish_run();
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, Busy}, 0);
        chk("rst_selway", {28'd0, SelWay}, 0);
        chk("rst_beat", {30'd0, BeatCount}, 0);
        chk("rst_wbreq", {31'd0, WriteBackReq}, 0);
        chk("rst_fetchreq", {31'd0, FetchReq}, 0);
        chk("rst_filldone", {31'd0, FillDone}, 0);
        chk("rst_setvalid", {31'd0, SetValid}, 0);
        chk("rst_lfsr_we", {31'd0, LFSRWriteEn}, 0);
        reset  = 1'b0;
        mon_en = 1;
        @(posedge clk);
        #1;
        run_txn(4'b1011, 4'b0000, 4'b0001, 0, 0, 0);
        run_txn(4'b1111, 4'b0000, 4'b1000, 0, 0, 0);
        run_txn(4'b1111, 4'b0010, 4'b0010, 0, 0, 1);
        run_txn(4'b1111, 4'b0000, 4'b0100, 3, 1, 0);
        run_txn(4'b1111, 4'b1111, 4'b0000, 0, 2, 0);
        run_txn(4'b1111, 4'b1010, 4'b0110, 0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            logic [N-1:0] v;
            v = ($urandom % 2 == 0) ? 4'b1111 : N'($urandom);
            run_txn(v, N'($urandom), N'($urandom),
                    ($urandom % 4 == 0) ? $urandom_range(1, 3) : 0, 2, 0);
        end
        chk("queue_drained", q.size(), 0);

        mon_en  = 0;
        Miss    = 1'b0;
        br_mode = 2;
        @(posedge clk);
        #1;
        BusReady   = 1'b0;
        ValidWay   = 4'b0000;
        DirtyWay   = 4'b0000;
        FlushStage = 1'b0;
        Miss       = 1'b1;
        @(posedge clk);
        #1;
        Miss     = 1'b0;
        BusReady = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        BusReady = 1'b0;
        @(negedge clk);
        chk("pre_rst_beat", {30'd0, BeatCount}, 2);
        chk("pre_rst_fetch", {31'd0, FetchReq}, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, Busy}, 0);
        chk("mid_rst_beat", {30'd0, BeatCount}, 0);
        chk("mid_rst_fetch", {31'd0, FetchReq}, 0);
        chk("mid_rst_selway", {28'd0, SelWay}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_setvalid", {31'd0, SetValid}, 0);
            chk("post_rst_busy", {31'd0, Busy}, 0);
        end
        finish_run();
    end

endmodule
